// File: rtl/sha2_sigma_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sha2_sigma_pipe
// Description : Pipelined SHA-2 sigma unit (Sigma0/Sigma1/sigma0/sigma1) for
//               32-bit (SHA-256) or 64-bit (SHA-512) words, with valid/ready
//               flow control, tag passthrough and an accepted-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sha2_sigma_pipe #(
    parameter int WORD_W      = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [1:0]        func_sel,
    input  logic [WORD_W-1:0] S_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [WORD_W-1:0] D_out,
    output logic [TAG_W-1:0]  tag_out,
    input  logic              clr_cnt,
    output logic [15:0]       op_count
);

    // Rotation / shift amounts for the selected word size
    localparam int c_EP0_A  = (WORD_W == 64) ? 28 : 2;
    localparam int c_EP0_B  = (WORD_W == 64) ? 34 : 13;
    localparam int c_EP0_C  = (WORD_W == 64) ? 39 : 22;
    localparam int c_EP1_A  = (WORD_W == 64) ? 14 : 6;
    localparam int c_EP1_B  = (WORD_W == 64) ? 18 : 11;
    localparam int c_EP1_C  = (WORD_W == 64) ? 41 : 25;
    localparam int c_SIG0_A = (WORD_W == 64) ? 1  : 7;
    localparam int c_SIG0_B = (WORD_W == 64) ? 8  : 18;
    localparam int c_SIG0_S = (WORD_W == 64) ? 7  : 3;
    localparam int c_SIG1_A = (WORD_W == 64) ? 19 : 17;
    localparam int c_SIG1_B = (WORD_W == 64) ? 61 : 19;
    localparam int c_SIG1_S = (WORD_W == 64) ? 6  : 10;

    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
        $error("sha2_sigma_pipe: WORD_W must be 32 or 64");
    end
    if (!(PIPE_STAGES == 1 || PIPE_STAGES == 2)) begin : g_bad_pipe_stages
        $error("sha2_sigma_pipe: PIPE_STAGES must be 1 or 2");
    end

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma(input logic [1:0] f, input logic [WORD_W-1:0] x);
        logic [WORD_W-1:0] r;
        case (f)
            2'd0:    r = rotr(x, c_EP0_A)  ^ rotr(x, c_EP0_B)  ^ rotr(x, c_EP0_C);
            2'd1:    r = rotr(x, c_EP1_A)  ^ rotr(x, c_EP1_B)  ^ rotr(x, c_EP1_C);
            2'd2:    r = rotr(x, c_SIG0_A) ^ rotr(x, c_SIG0_B) ^ (x >> c_SIG0_S);
            default: r = rotr(x, c_SIG1_A) ^ rotr(x, c_SIG1_B) ^ (x >> c_SIG1_S);
        endcase
        return r;
    endfunction

    // Output stage state
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] d_out_q, d_out_d;
    logic [TAG_W-1:0]  tag_out_q, tag_out_d;
    logic [15:0]       cnt_q, cnt_d;

    // What the stage feeding the output register presents
    logic              w_next_valid;
    logic [1:0]        w_next_func;
    logic [WORD_W-1:0] w_next_word;
    logic [TAG_W-1:0]  w_next_tag;
    logic              w_out_load;
    logic              w_ready_in;
    logic              w_accept;

    // Output register may take a new word when empty or being drained
    assign w_out_load = !out_valid_q || ready_out;
    assign w_accept   = valid_in && w_ready_in;

    if (PIPE_STAGES == 2) begin : g_two_stage
        logic              s1_valid_q, s1_valid_d;
        logic [1:0]        s1_func_q, s1_func_d;
        logic [WORD_W-1:0] s1_word_q, s1_word_d;
        logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

        // Stage 1 is free when empty or when its word moves to the output
        assign w_ready_in   = !s1_valid_q || w_out_load;
        assign w_next_valid = s1_valid_q;
        assign w_next_func  = s1_func_q;
        assign w_next_word  = s1_word_q;
        assign w_next_tag   = s1_tag_q;

        // Input capture: word, function and tag are taken together
        always_comb begin
            s1_valid_d = s1_valid_q;
            s1_func_d  = s1_func_q;
            s1_word_d  = s1_word_q;
            s1_tag_d   = s1_tag_q;
            if (w_ready_in) begin
                s1_valid_d = valid_in;
                if (valid_in) begin
                    s1_func_d = func_sel;
                    s1_word_d = S_in;
                    s1_tag_d  = tag_in;
                end
            end
        end

        // Stage 1 registers
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid_q <= 1'b0;
                s1_func_q  <= '0;
                s1_word_q  <= '0;
                s1_tag_q   <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_func_q  <= s1_func_d;
                s1_word_q  <= s1_word_d;
                s1_tag_q   <= s1_tag_d;
            end
        end
    end else begin : g_one_stage
        // Inputs feed the function and the output register directly
        assign w_ready_in   = w_out_load;
        assign w_next_valid = valid_in;
        assign w_next_func  = func_sel;
        assign w_next_word  = S_in;
        assign w_next_tag   = tag_in;
    end

    // Output stage and counter next-state; data holds when nothing loads
    always_comb begin
        out_valid_d = out_valid_q;
        d_out_d     = d_out_q;
        tag_out_d   = tag_out_q;
        cnt_d       = cnt_q;
        if (w_out_load) begin
            out_valid_d = w_next_valid;
            if (w_next_valid) begin
                d_out_d   = sigma(w_next_func, w_next_word);
                tag_out_d = w_next_tag;
            end
        end
        if (clr_cnt) begin
            cnt_d = w_accept ? 16'd1 : 16'd0;
        end else if (w_accept) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Output stage and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            d_out_q     <= '0;
            tag_out_q   <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            d_out_q     <= d_out_d;
            tag_out_q   <= tag_out_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ready_in  = w_ready_in;
    assign valid_out = out_valid_q;
    assign D_out     = d_out_q;
    assign tag_out   = tag_out_q;
    assign op_count  = cnt_q;

endmodule
`default_nettype wire
